// File: rtl/serial_reduce_using_mux_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : serial_reduce_using_mux_if
//  Purpose  : Request/result bundle for the bit-serial reduction block.
//             The producer issues a vector plus a reduction mode through a
//             valid/ready handshake. The block returns a one-cycle result
//             strobe with no backpressure.
//  Signals  : up_valid   producer -> block   request present
//             up_ready   block -> producer   request can be accepted
//             up_data    producer -> block   WIDTH-bit vector to reduce
//             up_mode    producer -> block   00 OR, 01 AND, 10 XOR, 11 NOR
//             down_valid block -> consumer   single-cycle result strobe
//             down_data  block -> consumer   result, held between strobes
//  Modports : master (producer/consumer side), slave (reduction block)
//  Revision : 1.0 - initial release
// ============================================================================
interface serial_reduce_using_mux_if #(
  parameter int WIDTH = 8
);
  logic             up_valid;
  logic             up_ready;
  logic [WIDTH-1:0] up_data;
  logic [1:0]       up_mode;
  logic             down_valid;
  logic             down_data;

  modport master (
    output up_valid,
    output up_data,
    output up_mode,
    input  up_ready,
    input  down_valid,
    input  down_data
  );

  modport slave (
    input  up_valid,
    input  up_data,
    input  up_mode,
    output up_ready,
    output down_valid,
    output down_data
  );
endinterface : serial_reduce_using_mux_if
`default_nettype wire

// File: rtl/serial_reduce_using_mux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : serial_reduce_using_mux
//  Purpose  : Reduces a WIDTH-bit vector (OR / AND / XOR / NOR) one bit per
//             clock, LSB first, with a 2:1 mux selected by the current bit as
//             the accumulator update. Emits a one-cycle result strobe.
//  Ports    : clk  - clock, rising edge
//             rst  - synchronous, active-high reset
//             bus  - slave side of serial_reduce_using_mux_if
//                    (up_valid/up_ready/up_data/up_mode in,
//                     down_valid/down_data out)
//  Params   : WIDTH      - bits per transaction (>= 2)
//             EARLY_EXIT - 1: OR/NOR/AND stop at the first deciding bit
//  Revision : 1.0 - initial release
// ============================================================================
module serial_reduce_using_mux #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  serial_reduce_using_mux_if.slave  bus
);

  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [1:0]     MODE_OR  = 2'b00;
  localparam logic [1:0]     MODE_AND = 2'b01;
  localparam logic [1:0]     MODE_XOR = 2'b10;
  localparam logic [1:0]     MODE_NOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] data_q;
  logic [1:0]       mode_q;
  logic [CW-1:0]    cnt_q;
  logic             acc_q;
  logic             down_valid_q;
  logic             down_data_q;

  logic             bit_d;
  logic             acc_d;
  logic             decided_d;
  logic             finish_d;
  logic             accept_d;

  // Ready is a pure function of state, gated by reset so the producer never
  // sees a ready while the block is being cleared.
  assign bus.up_ready   = (state_q != BUSY) && !rst;
  assign bus.down_valid = down_valid_q;
  assign bus.down_data  = down_data_q;
  assign accept_d       = bus.up_valid && bus.up_ready;

  // Accumulator update: a 2:1 mux selected by the bit under the counter.
  // OR and NOR share the OR datapath; NOR only inverts at the output.
  always_comb begin
    bit_d     = data_q[cnt_q];
    acc_d     = acc_q;
    decided_d = 1'b0;
    case (mode_q)
      MODE_AND: begin
        acc_d     = bit_d ? acc_q : 1'b0;
        decided_d = ~bit_d;
      end
      MODE_XOR: begin
        acc_d     = bit_d ? ~acc_q : acc_q;
      end
      default: begin
        acc_d     = bit_d ? 1'b1 : acc_q;
        decided_d = bit_d;
      end
    endcase
    finish_d = (cnt_q == CNT_LAST) || (EARLY_EXIT && decided_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      data_q       <= '0;
      mode_q       <= MODE_OR;
      cnt_q        <= '0;
      acc_q        <= 1'b0;
      down_valid_q <= 1'b0;
      down_data_q  <= 1'b0;
    end else begin
      down_valid_q <= 1'b0;
      case (state_q)
        // DONE accepts exactly like IDLE, which gives the WIDTH+1 cadence.
        IDLE, DONE: begin
          if (accept_d) begin
            data_q  <= bus.up_data;
            mode_q  <= bus.up_mode;
            cnt_q   <= '0;
            acc_q   <= (bus.up_mode == MODE_AND);
            state_q <= BUSY;
          end else begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (finish_d) begin
            state_q      <= DONE;
            down_valid_q <= 1'b1;
            down_data_q  <= (mode_q == MODE_NOR) ? ~acc_d : acc_d;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule : serial_reduce_using_mux
`default_nettype wire
